// File: rtl/simon_playback_sched_if.sv
// Handshake and pattern-RAM bus between the game core and the playback scheduler.
interface simon_playback_sched_if #(
  parameter int AW = 4
);
  logic          start;
  logic          abort;
  logic [7:0]    round;
  logic [AW-1:0] seq_addr;
  logic [1:0]    seq_data;
  logic [1:0]    color;
  logic          color_en;
  logic          busy;
  logic          done;

  // Core side: issues commands, owns the pattern RAM read data.
  modport master (
    output start, abort, round, seq_data,
    input  seq_addr, color, color_en, busy, done
  );

  // Scheduler side.
  modport slave (
    input  start, abort, round, seq_data,
    output seq_addr, color, color_en, busy, done
  );
endinterface

// File: rtl/simon_playback_sched.sv
// Simon pattern playback: walks the stored colour sequence, lighting each
// colour for ON_CYCLES and blanking for OFF_CYCLES, then pulses done.
module simon_playback_sched #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int MAX_ROUND  = 16,
  parameter int AW         = $clog2(MAX_ROUND)
) (
  input  logic                 clk,
  input  logic                 rst,
  simon_playback_sched_if.slave bus
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int LW      = AW + 1;

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_ROUND);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_ON,
    ST_OFF,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [LW-1:0] len_q, len_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    color_q, color_d;
  logic          color_en_q;
  logic          busy_q;
  logic          done_q;
  logic          last_idx;

  // Next-state, index, length, timer and colour selection.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    timer_d  = timer_q;
    color_d  = color_q;
    last_idx = ({1'b0, idx_q} == (len_q - LW'(1)));

    if (state_q != ST_IDLE && bus.abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            len_d   = (int'(bus.round) > MAX_ROUND) ? LEN_MAX : LW'(bus.round);
            idx_d   = '0;
            state_d = (len_d == '0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          color_d = bus.seq_data;
          timer_d = ON_LOAD;
          state_d = ST_ON;
        end
        ST_ON: begin
          if (timer_q == '0) begin
            timer_d = OFF_LOAD;
            state_d = ST_OFF;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        ST_OFF: begin
          if (timer_q == '0) begin
            if (last_idx) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + AW'(1);
              state_d = ST_FETCH;
            end
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      timer_q    <= '0;
      color_q    <= '0;
      color_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      timer_q    <= timer_d;
      color_q    <= color_d;
      color_en_q <= (state_d == ST_ON);
      busy_q     <= (state_d == ST_FETCH) || (state_d == ST_LOAD) ||
                    (state_d == ST_ON)    || (state_d == ST_OFF);
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign bus.seq_addr = idx_q;
  assign bus.color    = color_q;
  assign bus.color_en = color_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_simon_playback_sched.sv
// Bench for simon_playback_sched: directed scenarios plus random start/abort
// traffic, checked each cycle against a schedule computed arithmetically.
module tb_simon_playback_sched;

  localparam int ON   = 4;
  localparam int OFF  = 2;
  localparam int MAXR = 16;
  localparam int AW   = 4;
  localparam int PER  = ON + OFF + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  simon_playback_sched_if #(.AW(AW)) bus ();

  simon_playback_sched #(
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .MAX_ROUND (MAXR),
    .AW        (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  logic [1:0] ram [MAXR];

  // Pattern RAM with one-cycle read latency.
  always_ff @(posedge clk) bus.seq_data <= ram[bus.seq_addr];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference state: a playback started at cycle t0 with length mlen.
  bit active = 1'b0;
  int t0     = 0;
  int mlen   = 0;

  int   lit_edges = 0;
  int   max_addr  = 0;
  logic prev_en   = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: check outputs against the schedule, then apply inputs
  // that the next rising edge will sample.
  task automatic tick(input bit s, input bit a, input int r);
    int k, d, j, ph;
    bit e_busy, e_done, e_en, idle;
    @(negedge clk);
    cyc++;
    e_busy = 1'b0; e_done = 1'b0; e_en = 1'b0; j = 0; ph = 0;
    d = 1 + mlen * PER;
    k = cyc - t0;
    if (active) begin
      if (k < d) begin
        e_busy = 1'b1;
        j      = (k - 1) / PER;
        ph     = (k - 1) % PER;
        e_en   = (ph >= 2) && (ph < 2 + ON);
      end else if (k == d) begin
        e_done = 1'b1;
      end
    end
    check_eq("busy", int'(bus.busy), int'(e_busy));
    check_eq("done", int'(bus.done), int'(e_done));
    check_eq("color_en", int'(bus.color_en), int'(e_en));
    if (e_busy) check_eq("seq_addr", int'(bus.seq_addr), j);
    if (e_busy && ph >= 2) check_eq("color", int'(bus.color), int'(ram[j]));

    if (bus.color_en && !prev_en) lit_edges++;
    prev_en = bus.color_en;
    if (bus.busy && int'(bus.seq_addr) > max_addr) max_addr = int'(bus.seq_addr);

    idle = !active || (k > d);
    if (a) begin
      if (!idle) active = 1'b0;
    end else if (s && idle) begin
      active = 1'b1;
      t0     = cyc;
      mlen   = (r > MAXR) ? MAXR : r;
    end
    bus.start = s;
    bus.abort = a;
    bus.round = 8'(r);
  endtask

  initial begin
    int rr, sel;
    bit ss, aa;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.round = '0;
    ram[0] = 2'd2; ram[1] = 2'd0; ram[2] = 2'd3; ram[3] = 2'd1;
    for (int i = 4; i < MAXR; i++) ram[i] = 2'($urandom_range(0, 3));

    // Held in reset.
    #3;
    check_eq("rst_color_en", int'(bus.color_en), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_done", int'(bus.done), 0);
    check_eq("rst_seq_addr", int'(bus.seq_addr), 0);
    #9 rst = 1'b1;

    repeat (100) tick(0, 0, 0);

    // Play 3 with an ignored start five cycles in.
    tick(1, 0, 3);
    repeat (4) tick(0, 0, 0);
    tick(1, 0, 7);
    repeat (30) tick(0, 0, 0);

    // Zero-length round.
    tick(1, 0, 0);
    repeat (5) tick(0, 0, 0);

    // Clamped round.
    lit_edges = 0;
    max_addr  = 0;
    tick(1, 0, 20);
    repeat (135) tick(0, 0, 0);
    check_eq("clamp_lit_intervals", lit_edges, 16);
    check_eq("clamp_max_addr", max_addr, 15);

    // Abort mid-playback, then a fresh start.
    tick(1, 0, 4);
    repeat (11) tick(0, 0, 0);
    tick(0, 1, 0);
    repeat (2) tick(0, 0, 0);
    tick(1, 0, 4);
    repeat (40) tick(0, 0, 0);

    // Start and abort together while idle.
    tick(1, 1, 5);
    repeat (3) tick(0, 0, 0);

    // Asynchronous reset while a colour is lit.
    tick(1, 0, 3);
    repeat (4) tick(0, 0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("async_color_en", int'(bus.color_en), 0);
    check_eq("async_busy", int'(bus.busy), 0);
    check_eq("async_seq_addr", int'(bus.seq_addr), 0);
    check_eq("async_done", int'(bus.done), 0);
    #1 rst = 1'b1;
    active = 1'b0;
    repeat (5) tick(0, 0, 0);

    // Random start/abort traffic.
    repeat (3000) begin
      ss  = ($urandom_range(0, 9) == 0);
      aa  = ($urandom_range(0, 59) == 0);
      sel = $urandom_range(0, 7);
      if (sel == 0)      rr = 0;
      else if (sel == 1) rr = $urandom_range(17, 255);
      else               rr = $urandom_range(1, 6);
      tick(ss, aa, rr);
    end
    repeat (150) tick(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
